// File: rtl/rts_pkg.sv
// Shared definitions for the RTS BIST blocks: FSM state encoding, error codes, default MISR polynomial.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package rts_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_SHIFT   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_SIGN    = 3'd4,
      ST_DONE    = 3'd5,
      ST_ERROR   = 3'd6
   } rts_state_e;

   // Error codes reported on err_code; the first one seen after a restart is kept.
   localparam logic [2:0] ERR_NONE       = 3'd0;
   localparam logic [2:0] ERR_PROTO      = 3'd1;  // illegal strobe combination / NbarT low while shifting
   localparam logic [2:0] ERR_SEQ        = 3'd2;  // expected strobe missing
   localparam logic [2:0] ERR_SHIFT      = 3'd3;  // short or long shift, or dirty capture cycle
   localparam logic [2:0] ERR_CAPTURE    = 3'd4;  // no MISR_En in capture
   localparam logic [2:0] ERR_EARLY_DONE = 3'd5;  // done before all vectors were applied
   localparam logic [2:0] ERR_DONE_DROP  = 3'd6;  // done released after completion
   localparam logic [2:0] ERR_WDOG       = 3'd7;  // controller stalled

   localparam logic [15:0] RTS_MISR_POLY = 16'h1021;

   // Saturating increment for the 11-bit vector counter.
   function automatic logic [10:0] sat_inc11(input logic [10:0] v);
      return (v == 11'h7FF) ? v : v + 11'd1;
   endfunction

endpackage

// File: rtl/rts_misr.sv
// Multiple-input signature register: shifts left with polynomial feedback and folds in a zero-extended data word.
// Latency: one cycle from en_i to the updated sig_o; clr_i wins over en_i.
// Backpressure: none; every enabled cycle is compacted.
module rts_misr
   import rts_pkg::*;
#(
   parameter int                  SigWidth  = 16,
   parameter int                  DataWidth = 16,
   parameter logic [SigWidth-1:0] MisrPoly  = SigWidth'(RTS_MISR_POLY)
) (
   input  logic                 clk,
   input  logic                 rstIn,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic [DataWidth-1:0] data_i,
   output logic [SigWidth-1:0]  sig_o
);

   logic [SigWidth-1:0] sig_q, sig_d;
   logic [SigWidth-1:0] data_ext;

   // Zero-extend the response to the signature width (works for equal widths too).
   always_comb begin
      data_ext                = '0;
      data_ext[DataWidth-1:0] = data_i;
   end

   // Next signature: clear, compact, or hold.
   always_comb begin
      sig_d = sig_q;
      if (clr_i) begin
         sig_d = '0;
      end else if (en_i) begin
         sig_d = {sig_q[SigWidth-2:0], 1'b0}
               ^ (sig_q[SigWidth-1] ? MisrPoly : '0)
               ^ data_ext;
      end
   end

   // Signature register.
   always_ff @(posedge clk or posedge rstIn) begin
      if (rstIn) sig_q <= '0;
      else       sig_q <= sig_d;
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/rts_bist_monitor.sv
// Checks the RTS BIST controller strobe sequence per vector, compacts CUT responses, grades the final signature.
// Latency: outputs registered; errors show the cycle after the offending input, pass/fail one cycle after DONE entry.
// Backpressure: none; strobes are consumed every cycle and violations are flagged, never stalled.
// Optional: define RTS_MON_WATCHDOG_EN to add a stall watchdog reporting err 7.
module rts_bist_monitor
   import rts_pkg::*;
#(
   parameter int                  ShiftSize    = 45,
   parameter int                  numOfTstCycl = 45,
   parameter int                  RespWidth    = 16,
   parameter int                  SigWidth     = 16,
   parameter logic [SigWidth-1:0] MisrPoly     = SigWidth'(RTS_MISR_POLY),
   parameter logic [SigWidth-1:0] GoldenSig    = '0
) (
   input  logic                 clk,
   input  logic                 rstIn,
   input  logic                 rstOut,
   input  logic                 NbarT,
   input  logic                 PRPG_En,
   input  logic                 SRSG_En,
   input  logic                 SISA_En,
   input  logic                 MISR_En,
   input  logic                 done,
   input  logic [RespWidth-1:0] resp_in,
   output logic [SigWidth-1:0]  signature,
   output logic [10:0]          vec_count,
   output logic                 busy,
   output logic                 pass,
   output logic                 fail,
   output logic [2:0]           err_code
);

   localparam logic [15:0] SHIFT_CNT = 16'(ShiftSize);
   localparam logic [10:0] NUM_VEC   = 11'(numOfTstCycl);

   rts_state_e  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [10:0] vec_q, vec_d;
   logic        pass_q, pass_d;
   logic        fail_q, fail_d;
   logic [2:0]  err_q, err_d;
   logic        misr_clr, misr_en;
   logic        err_hit;
   logic [2:0]  err_val;
   logic [3:0]  strb;
   logic        legal;
   logic        any_strobe;

   // At most one of the exclusive strobes, and the shift/compaction pair must agree.
   assign strb       = {PRPG_En, SRSG_En, MISR_En, done};
   assign legal      = (SRSG_En == SISA_En) && ((strb & (strb - 4'd1)) == 4'd0);
   assign any_strobe = |{PRPG_En, SRSG_En, SISA_En, MISR_En, done};
   assign busy       = (state_q == ST_ARMED) || (state_q == ST_SHIFT) ||
                       (state_q == ST_CAPTURE) || (state_q == ST_SIGN);

`ifdef RTS_MON_WATCHDOG_EN
   localparam logic [15:0] WDOG_LIMIT = 16'(ShiftSize + 8);
   logic [15:0] wdog_q, wdog_d;

   // Cycles spent in the current state, saturating.
   always_comb begin
      wdog_d = wdog_q;
      if (state_d != state_q)     wdog_d = '0;
      else if (wdog_q != 16'hFFFF) wdog_d = wdog_q + 16'd1;
   end

   // Watchdog counter register.
   always_ff @(posedge clk or posedge rstIn) begin
      if (rstIn) wdog_q <= '0;
      else       wdog_q <= wdog_d;
   end
`endif

   // Sequence checker: next state, counters, verdict and first-error capture.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      vec_d    = vec_q;
      pass_d   = pass_q;
      fail_d   = fail_q;
      err_d    = err_q;
      misr_clr = 1'b0;
      misr_en  = 1'b0;
      err_hit  = 1'b0;
      err_val  = ERR_NONE;
      if (rstOut) begin
         state_d  = ST_ARMED;
         cnt_d    = '0;
         vec_d    = '0;
         pass_d   = 1'b0;
         fail_d   = 1'b0;
         err_d    = ERR_NONE;
         misr_clr = 1'b1;
      end else begin
         if ((state_q != ST_IDLE) && (state_q != ST_ERROR) && !legal) begin
            err_hit = 1'b1;
            err_val = ERR_PROTO;
         end else begin
            case (state_q)
               ST_ARMED: begin
                  if (PRPG_En) begin
                     state_d = ST_SHIFT;
                     cnt_d   = '0;
                  end else begin
                     err_hit = 1'b1;
                     err_val = (done && (vec_q < NUM_VEC)) ? ERR_EARLY_DONE : ERR_SEQ;
                  end
               end
               ST_SHIFT: begin
                  if (SRSG_En) begin
                     if (!NbarT) begin
                        err_hit = 1'b1;
                        err_val = ERR_PROTO;
                     end else if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                     end
                  end else if ((cnt_q == SHIFT_CNT) && !any_strobe && !NbarT) begin
                     state_d = ST_CAPTURE;
                  end else begin
                     err_hit = 1'b1;
                     err_val = ERR_SHIFT;
                  end
               end
               ST_CAPTURE: begin
                  if (MISR_En) begin
                     state_d = ST_SIGN;
                     misr_en = 1'b1;
                     vec_d   = sat_inc11(vec_q);
                  end else begin
                     err_hit = 1'b1;
                     err_val = ERR_CAPTURE;
                  end
               end
               ST_SIGN: begin
                  if (vec_q < NUM_VEC) begin
                     if (PRPG_En) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                     end else begin
                        err_hit = 1'b1;
                        err_val = done ? ERR_EARLY_DONE : ERR_SEQ;
                     end
                  end else if (done) begin
                     state_d = ST_DONE;
                  end else begin
                     err_hit = 1'b1;
                     err_val = ERR_SEQ;
                  end
               end
               ST_DONE: begin
                  if (!done) begin
                     err_hit = 1'b1;
                     err_val = ERR_DONE_DROP;
                  end else begin
                     pass_d = (signature == GoldenSig);
                     fail_d = (signature != GoldenSig);
                  end
               end
               default: ;  // IDLE and ERROR only leave on rstOut
            endcase
         end
`ifdef RTS_MON_WATCHDOG_EN
         if (!err_hit && busy && (wdog_q >= WDOG_LIMIT)) begin
            err_hit = 1'b1;
            err_val = ERR_WDOG;
         end
`endif
         if (err_hit) begin
            state_d = ST_ERROR;
            pass_d  = 1'b0;
            fail_d  = 1'b1;
            if (err_q == ERR_NONE) err_d = err_val;
         end
      end
   end

   // State and status registers.
   always_ff @(posedge clk or posedge rstIn) begin
      if (rstIn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         vec_q   <= '0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         err_q   <= err_d;
      end
   end

   rts_misr #(
      .SigWidth  (SigWidth),
      .DataWidth (RespWidth),
      .MisrPoly  (MisrPoly)
   ) u_misr (
      .clk    (clk),
      .rstIn  (rstIn),
      .clr_i  (misr_clr),
      .en_i   (misr_en),
      .data_i (resp_in),
      .sig_o  (signature)
   );

   assign vec_count = vec_q;
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign err_code  = err_q;

endmodule

// File: tb/tb_rts_bist_monitor.sv
// Bench for rts_bist_monitor: two instances share stimulus, one with the true golden signature, one off by bit 0.
// Latency: expected outputs are checked on the falling edge after the rising edge that consumes each input cycle.
// Backpressure: not applicable.
module tb_rts_bist_monitor;

   // Hand-computed signatures for responses 00A5, 1234, FFFF with polynomial 1021.
   localparam logic [15:0] SIG1 = 16'h00A5;
   localparam logic [15:0] SIG2 = 16'h137E;
   localparam logic [15:0] SIG3 = 16'hD903;
   localparam logic [15:0] GOLD = SIG3;

   // Strobe patterns: {rstOut, NbarT, PRPG_En, SRSG_En, SISA_En, MISR_En, done}
   localparam logic [6:0] S_RST   = 7'b1000000;
   localparam logic [6:0] S_PRPG  = 7'b0110000;
   localparam logic [6:0] S_SHIFT = 7'b0101100;
   localparam logic [6:0] S_IDLE  = 7'b0000000;
   localparam logic [6:0] S_MISR  = 7'b0000010;
   localparam logic [6:0] S_DONE  = 7'b0000001;
   localparam logic [6:0] S_TWO   = 7'b0110010;

   logic        clk = 1'b0;
   logic        rstIn, rstOut, NbarT, PRPG_En, SRSG_En, SISA_En, MISR_En, done;
   logic [15:0] resp_in;
   logic [15:0] sig_a, sig_b;
   logic [10:0] vec_a, vec_b;
   logic        busy_a, busy_b, pass_a, pass_b, fail_a, fail_b;
   logic [2:0]  err_a, err_b;

   always #5 clk = ~clk;

   rts_bist_monitor #(
      .ShiftSize(4), .numOfTstCycl(3), .RespWidth(16), .SigWidth(16),
      .MisrPoly(16'h1021), .GoldenSig(GOLD)
   ) u_dut (
      .clk(clk), .rstIn(rstIn), .rstOut(rstOut), .NbarT(NbarT), .PRPG_En(PRPG_En),
      .SRSG_En(SRSG_En), .SISA_En(SISA_En), .MISR_En(MISR_En), .done(done),
      .resp_in(resp_in), .signature(sig_a), .vec_count(vec_a), .busy(busy_a),
      .pass(pass_a), .fail(fail_a), .err_code(err_a)
   );

   rts_bist_monitor #(
      .ShiftSize(4), .numOfTstCycl(3), .RespWidth(16), .SigWidth(16),
      .MisrPoly(16'h1021), .GoldenSig(GOLD ^ 16'h0001)
   ) u_bad (
      .clk(clk), .rstIn(rstIn), .rstOut(rstOut), .NbarT(NbarT), .PRPG_En(PRPG_En),
      .SRSG_En(SRSG_En), .SISA_En(SISA_En), .MISR_En(MISR_En), .done(done),
      .resp_in(resp_in), .signature(sig_b), .vec_count(vec_b), .busy(busy_b),
      .pass(pass_b), .fail(fail_b), .err_code(err_b)
   );

   typedef struct packed {
      int          due;
      logic        busy;
      logic [10:0] vec;
      logic [15:0] sig;
      logic        pass;
      logic        fail;
      logic [2:0]  err;
      logic        bpass;
      logic        bfail;
      logic [2:0]  berr;
   } exp_t;

   exp_t exp_q[$];
   exp_t m;
   event kick;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   // Expected outputs after the cycle currently being driven.
   logic        x_busy, x_pass, x_fail, x_bpass, x_bfail;
   logic [10:0] x_vec;
   logic [15:0] x_sig;
   logic [2:0]  x_err, x_berr;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: pops every expectation that has come due and compares both instances.
   always begin
      @(negedge clk or kick);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         m = exp_q.pop_front();
         chk("busy",      16'(busy_a), 16'(m.busy));
         chk("vec_count", 16'(vec_a),  16'(m.vec));
         chk("signature", sig_a,       m.sig);
         chk("pass",      16'(pass_a), 16'(m.pass));
         chk("fail",      16'(fail_a), 16'(m.fail));
         chk("err_code",  16'(err_a),  16'(m.err));
         chk("bad_sig",   sig_b,       m.sig);
         chk("bad_pass",  16'(pass_b), 16'(m.bpass));
         chk("bad_fail",  16'(fail_b), 16'(m.bfail));
         chk("bad_err",   16'(err_b),  16'(m.berr));
      end
   end

   task automatic push(input int due);
      exp_t e;
      e.due = due;   e.busy = x_busy; e.vec = x_vec;   e.sig = x_sig;
      e.pass = x_pass; e.fail = x_fail; e.err = x_err;
      e.bpass = x_bpass; e.bfail = x_bfail; e.berr = x_berr;
      exp_q.push_back(e);
   endtask

   task automatic clr_x();
      x_busy = 0; x_vec = '0; x_sig = '0; x_pass = 0; x_fail = 0; x_err = '0;
      x_bpass = 0; x_bfail = 0; x_berr = '0;
   endtask

   task automatic set_err(input logic [2:0] code);
      x_busy = 0; x_pass = 0; x_fail = 1; x_err = code;
      x_bpass = 0; x_bfail = 1; x_berr = code;
   endtask

   task automatic step(input logic [6:0] s, input logic [15:0] r);
      @(posedge clk);
      #2;
      {rstOut, NbarT, PRPG_En, SRSG_En, SISA_En, MISR_En, done} = s;
      resp_in = r;
      push(cyc + 1);
   endtask

   task automatic arm();
      clr_x();
      x_busy = 1;
      step(S_RST, 16'h0);
   endtask

   task automatic vec(input logic [15:0] r, input logic [10:0] v, input logic [15:0] s);
      step(S_PRPG, 16'h0);
      repeat (4) step(S_SHIFT, 16'h0);
      step(S_IDLE, 16'h0);
      x_vec = v; x_sig = s;
      step(S_MISR, r);
   endtask

   task automatic full_run();
      vec(16'h00A5, 11'd1, SIG1);
      vec(16'h1234, 11'd2, SIG2);
      vec(16'hFFFF, 11'd3, SIG3);
      x_busy = 0;
      step(S_DONE, 16'h0);
      x_pass = 1; x_bfail = 1;
      step(S_DONE, 16'h0);
      step(S_DONE, 16'h0);
   endtask

   initial begin
      rstIn = 1;
      {rstOut, NbarT, PRPG_En, SRSG_En, SISA_En, MISR_En, done} = S_IDLE;
      resp_in = '0;
      clr_x();
      #1 push(cyc);
      @(posedge clk); #2 rstIn = 0;

      // IDLE ignores strobes until rstOut
      step(S_PRPG, 16'h0);
      step(S_SHIFT, 16'h0);

      // Nominal run: good golden passes, off-by-one golden fails with no error code
      arm();
      full_run();

      // Mid-run restart, then a clean rerun
      arm();
      vec(16'h00A5, 11'd1, SIG1);
      arm();
      full_run();

      // Short shift: three shift cycles then the capture cycle
      arm();
      step(S_PRPG, 16'h0);
      repeat (3) step(S_SHIFT, 16'h0);
      set_err(3'd3);
      step(S_IDLE, 16'h0);
      step(S_IDLE, 16'h0);

      // Two strobes in SIGN; later violations must not overwrite the code
      arm();
      vec(16'h00A5, 11'd1, SIG1);
      set_err(3'd1);
      step(S_TWO, 16'hFFFF);
      step(S_IDLE, 16'h0);
      step(S_MISR, 16'hFFFF);

      // Early done after vector 2 of 3
      arm();
      vec(16'h00A5, 11'd1, SIG1);
      vec(16'h1234, 11'd2, SIG2);
      set_err(3'd5);
      step(S_DONE, 16'h0);

      // Idle cycle in ARMED
      arm();
      set_err(3'd2);
      step(S_IDLE, 16'h0);

      // Asynchronous reset in the middle of a shift
      arm();
      step(S_PRPG, 16'h0);
      step(S_SHIFT, 16'h0);
      @(posedge clk);
      @(negedge clk);
      #1;
      rstIn = 1;
      clr_x();
      push(cyc);
      #1 -> kick;
      step(S_SHIFT, 16'h0);
      rstIn = 0;
      step(S_PRPG, 16'h0);
      step(S_SHIFT, 16'h0);
      arm();

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rts_bist_monitor.md
Name: rts_bist_monitor

Overview:
- Receiving end of the STUMPS-style RTS BIST control interface. Sits beside the BIST controller and the CUT.
- Consumes the controller strobes (rstOut, NbarT, PRPG_En, SRSG_En, SISA_En, MISR_En, done) and checks that they follow the legal per-vector sequence.
- Compacts CUT responses into a local MISR on every MISR_En cycle. On done, compares the signature with a golden value and reports pass/fail plus any protocol error.

Parameters:
- ShiftSize, 45, required SRSG_En cycles per vector.
- numOfTstCycl, 45, required vectors before done.
- RespWidth, 16, CUT response width; must be <= SigWidth.
- SigWidth, 16, MISR width.
- MisrPoly, 16'h1021, feedback polynomial (bit i set = tap i).
- GoldenSig, 16'h0000, expected final signature.

Ports:
- clk  in  1  clock
- rstIn  in  1  reset, asynchronous, active-high
- rstOut  in  1  controller restart strobe
- NbarT  in  1  1 = test/shift, 0 = normal capture
- PRPG_En  in  1  pattern generate strobe
- SRSG_En  in  1  shift strobe
- SISA_En  in  1  shift compaction strobe
- MISR_En  in  1  signature strobe
- done  in  1  controller finished, level
- resp_in  in  RespWidth  CUT response, sampled when MISR_En=1
- signature  out  SigWidth  current MISR value
- vec_count  out  11  vectors completed
- busy  out  1  sequence in progress
- pass  out  1  sticky, final signature == GoldenSig and no error
- fail  out  1  sticky, mismatch or protocol error
- err_code  out  3  first error captured; 0 = none

Behaviour:
- Reset (rstIn): state IDLE; signature=0, vec_count=0, internal shift count=0, busy=0, pass=0, fail=0, err_code=0.
- rstOut=1 in any state, including ERROR/DONE: next cycle state ARMED; signature, counts, pass, fail and err_code all cleared. rstOut takes priority over all other inputs in that cycle.
- Legal-cycle rule: SRSG_En must equal SISA_En. Outside the rstOut cycle, at most one of {PRPG_En, SRSG_En, MISR_En, done} may be high. Violation -> err_code=1.
- FSM:
  - IDLE: wait for rstOut; busy=0.
  - ARMED: expect PRPG_En -> SHIFT, with shift count cleared. An idle cycle is an error (err 2). done with vec_count<numOfTstCycl is also an error (err 5).
  - SHIFT: each SRSG_En cycle increments the count; NbarT must be 1, else err 1. The first non-shift cycle must have count==ShiftSize and all strobes low with NbarT=0, and then -> CAPTURE; any other case is err 3 (short or long shift).
  - CAPTURE: expect MISR_En=1 -> SIGN; MISR updates this cycle; vec_count increments. Anything else is err 4.
  - SIGN: if vec_count<numOfTstCycl, expect PRPG_En -> SHIFT (count cleared). If vec_count==numOfTstCycl, expect done -> DONE. Any mismatch is err 2 or err 5 as appropriate.
  - DONE: one cycle after entry, pass=(signature==GoldenSig) and fail=!pass. Then hold while done=1. done deasserting in DONE is err 6.
  - ERROR: fail=1, err_code latched (first error wins); sticky until rstOut or rstIn.
- busy=1 in ARMED, SHIFT, CAPTURE and SIGN.
- MISR update: sig_next = {sig[SigWidth-2:0],1'b0} ^ (sig[SigWidth-1] ? MisrPoly : 0) ^ zero-extended resp_in.
- vec_count saturates at its 11-bit maximum and never wraps.
- pass and fail are never both 1.

Optional Feature:
- Macro: RTS_MON_WATCHDOG_EN.
- With the macro: a 16-bit cycle counter clears on every state change. If it reaches ShiftSize+8 while busy, the monitor enters ERROR with err_code=7.
- Without the macro: no watchdog; a stalled controller leaves busy=1 indefinitely.

Decomposition:
- Shared package rts_pkg holds:
  - state encodings (IDLE, ARMED, SHIFT, CAPTURE, SIGN, DONE, ERROR);
  - error-code constants ERR_NONE..ERR_WDOG (0..7);
  - the default MISR polynomial.
- One sub-module, rts_misr: parameterised SigWidth/MisrPoly register with clear and enable, reused by other BIST blocks.

Test Plan:
- Nominal run: ShiftSize=4, numOfTstCycl=3, resp_in=16'h00A5,16'h1234,16'hFFFF, GoldenSig set to the model value -> vec_count=3, pass=1, fail=0, err_code=0.
- Short shift: only 3 SRSG_En cycles before the capture cycle -> fail=1, err_code=3 on the following cycle.
- Two strobes: PRPG_En and MISR_En both high in SIGN -> err_code=1. A later error does not overwrite it.
- Early done: done asserted after vector 2 of 3 -> err_code=5, pass=0.
- Signature mismatch: GoldenSig off by bit 0 -> fail=1, err_code=0. A mid-run rstOut then clears everything, and a rerun with the correct golden gives pass=1.
- rstIn asserted during SHIFT -> all outputs 0 immediately (asynchronous); state IDLE ignores strobes until rstOut.
